pll_dri_master: RTL and testbench

PLL_DRI_MASTER -- requirements
Module: pll_dri_master

---
 rtl/pll_dri_master_pkg.sv | 31 +++
 rtl/pll_dri_master.sv | 181 ++++++++++++++++++
 tb/tb_pll_dri_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_dri_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_dri_master_pkg
// Description : Shared definitions for the PLL DRI (APB-style) master:
//               FSM state encoding, DRI_CTRL bit positions and the width of
//               the ACCESS-phase timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_dri_master_pkg;

    // Host-access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // DRI_CTRL layout: {PSEL, PENABLE, PWRITE, PADDR[7:0]}
    localparam int C_CTRL_W           = 11;
    localparam int C_CTRL_PSEL_BIT    = 10;
    localparam int C_CTRL_PENABLE_BIT = 9;
    localparam int C_CTRL_PWRITE_BIT  = 8;
    localparam int C_CTRL_PADDR_MSB   = 7;
    localparam int C_CTRL_PADDR_LSB   = 0;

    // ACCESS-cycle counter width (TIMEOUT legal range 1..1023)
    localparam int C_CNT_W = 10;

endpackage : pll_dri_master_pkg
`default_nettype wire

// File: rtl/pll_dri_master.sv
`default_nettype none
// ============================================================================
// Module      : pll_dri_master
// Description : Bridges a simple REQ/ACK host port onto the PLL DRI (APB-like)
//               register bus. Each access runs IDLE -> SETUP -> ACCESS -> DONE,
//               with an ACCESS-phase timeout that completes the access with ERR.
// Ports       : CLK/RESET          - clock, asynchronous active-high reset
//               REQ/WE/ADDR/WDATA  - host request (held until ACK)
//               ACK/RDATA/ERR      - host completion, read data, timeout flag
//               IRQ                - DRI_INTERRUPT delayed by one clock
//               DRI_CLK/DRI_CTRL/DRI_WDATA/DRI_RDATA/DRI_ARST_N/DRI_INTERRUPT
//                                  - PLL DRI bus
// Revision    : 1.0 - initial release
// ============================================================================
module pll_dri_master
    import pll_dri_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [7:0]  ADDR,
    input  logic [31:0] WDATA,
    output logic        ACK,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        IRQ,
    output logic        DRI_CLK,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    input  logic [32:0] DRI_RDATA,
    output logic        DRI_ARST_N,
    input  logic        DRI_INTERRUPT
);

    // Counter value seen during the TIMEOUT-th ACCESS cycle
    localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_arst_sync;
    logic                 r_we;
    logic [7:0]           r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_err;
    logic                 r_irq;

    logic                 w_pready;
    logic                 w_timeout;
    logic                 w_start;
    logic                 w_sel;
    logic                 w_enable;

    assign w_pready  = DRI_RDATA[32];
    assign w_timeout = (r_cnt == C_TIMEOUT_LAST);
    // DRI reset must be released before any access may begin
    assign w_start   = REQ & r_arst_sync[1];

    // ------------------------------------------------------------------------
    // DRI reset release: asserts with RESET, deasserts on the 2nd edge after
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_arst_sync <= 2'b00;
        end else begin
            r_arst_sync <= {r_arst_sync[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and bus strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_sel    = 1'b0;
        w_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_sel  = 1'b1;
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_sel    = 1'b1;
                w_enable = 1'b1;
                if (w_pready || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: host capture, ACCESS counter, read data and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_we    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= DRI_INTERRUPT;
            case (r_state)
                ST_IDLE: begin
                    // Counter and error are cleared so SETUP always starts fresh
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_start) begin
                        r_we    <= WE;
                        r_addr  <= ADDR;
                        r_wdata <= WDATA;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    // PREADY takes priority over a coincident timeout
                    if (w_pready) begin
                        r_err <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= DRI_RDATA[31:0];
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        DRI_CTRL                                      = '0;
        DRI_CTRL[C_CTRL_PSEL_BIT]                     = w_sel;
        DRI_CTRL[C_CTRL_PENABLE_BIT]                  = w_enable;
        DRI_CTRL[C_CTRL_PWRITE_BIT]                   = w_sel & r_we;
        DRI_CTRL[C_CTRL_PADDR_MSB:C_CTRL_PADDR_LSB]   = w_sel ? r_addr : 8'h00;
    end

    assign ACK        = (r_state == ST_DONE);
    assign ERR        = (r_state == ST_DONE) & r_err;
    assign RDATA      = r_rdata;
    assign IRQ        = r_irq;
    assign DRI_CLK    = CLK;
    assign DRI_WDATA  = {1'b0, r_wdata};
    assign DRI_ARST_N = r_arst_sync[1];

endmodule : pll_dri_master
`default_nettype wire

// File: tb/tb_pll_dri_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_dri_master
// Description : Self-checking bench. Two instances (TIMEOUT=4 and default 255)
//               share host fields and DRI read bus, each with its own REQ.
//               Expected ACK cycle, ERR, RDATA and bus fields come from a
//               transaction-level model of the access protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_dri_master;

    localparam int C_T_A = 4;
    localparam int C_T_B = 255;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [32:0] dri_rdata;
    logic        intr;

    logic [1:0]  ack_w;
    logic [1:0]  err_w;
    logic [1:0]  irq_w;
    logic [1:0]  dclk_w;
    logic [1:0]  arstn_w;
    logic [31:0] rdata_w [2];
    logic [10:0] ctrl_w  [2];
    logic [32:0] dwd_w   [2];

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_rd [2];

    pll_dri_master #(.TIMEOUT(C_T_A)) u_dut_a (
        .CLK(clk), .RESET(rst), .REQ(req[0]), .WE(we), .ADDR(addr), .WDATA(wdata),
        .ACK(ack_w[0]), .RDATA(rdata_w[0]), .ERR(err_w[0]), .IRQ(irq_w[0]),
        .DRI_CLK(dclk_w[0]), .DRI_CTRL(ctrl_w[0]), .DRI_WDATA(dwd_w[0]),
        .DRI_RDATA(dri_rdata), .DRI_ARST_N(arstn_w[0]), .DRI_INTERRUPT(intr)
    );

    pll_dri_master #(.TIMEOUT(C_T_B)) u_dut_b (
        .CLK(clk), .RESET(rst), .REQ(req[1]), .WE(we), .ADDR(addr), .WDATA(wdata),
        .ACK(ack_w[1]), .RDATA(rdata_w[1]), .ERR(err_w[1]), .IRQ(irq_w[1]),
        .DRI_CLK(dclk_w[1]), .DRI_CTRL(ctrl_w[1]), .DRI_WDATA(dwd_w[1]),
        .DRI_RDATA(dri_rdata), .DRI_ARST_N(arstn_w[1]), .DRI_INTERRUPT(intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One access on both instances. waits = ACCESS cycles with PREADY low
    // before it rises. Called at a negedge with both instances idle.
    task automatic do_txn(input logic we_i, input logic [7:0] addr_i,
                          input logic [31:0] wdata_i, input int waits,
                          input logic [31:0] rd_i);
        int          exp_c [2];
        logic        exp_e [2];
        logic [1:0]  done;
        int          tmo   [2];
        logic [10:0] e_ctrl;
        tmo[0] = C_T_A;
        tmo[1] = C_T_B;
        for (int d = 0; d < 2; d++) begin
            // ACK follows SETUP, (waits+1) ACCESS cycles; or TIMEOUT ACCESS cycles
            exp_e[d] = (waits >= tmo[d]);
            exp_c[d] = exp_e[d] ? tmo[d] + 2 : waits + 3;
        end
        we        = we_i;
        addr      = addr_i;
        wdata     = wdata_i;
        req       = 2'b11;
        dri_rdata = {1'b0, $urandom};
        done      = 2'b00;
        for (int c = 1; c <= 300 && done != 2'b11; c++) begin
            @(negedge clk);
            chk("irq_a", irq_w[0], intr);
            chk("irq_b", irq_w[1], intr);
            for (int d = 0; d < 2; d++) begin
                if (!done[d]) begin
                    chk($sformatf("ack%0d_c%0d", d, c), ack_w[d], c == exp_c[d]);
                    if (c == 1)
                        e_ctrl = {1'b1, 1'b0, we_i, addr_i};
                    else if (c < exp_c[d])
                        e_ctrl = {1'b1, 1'b1, we_i, addr_i};
                    else
                        e_ctrl = 11'h0;
                    chk($sformatf("ctrl%0d_c%0d", d, c), ctrl_w[d], e_ctrl);
                    chk($sformatf("dwd%0d_c%0d", d, c), dwd_w[d], {1'b0, wdata_i});
                    if (c == exp_c[d]) begin
                        if (!exp_e[d] && !we_i) exp_rd[d] = rd_i;
                        chk($sformatf("err%0d", d), err_w[d], exp_e[d]);
                        chk($sformatf("rdata%0d", d), rdata_w[d], exp_rd[d]);
                        done[d] = 1'b1;
                        req[d]  = 1'b0;
                    end else begin
                        chk($sformatf("err_idle%0d", d), err_w[d], 1'b0);
                    end
                end
            end
            // Host fields become don't-care once captured
            we    = $urandom_range(0, 1);
            addr  = $urandom;
            wdata = $urandom;
            intr  = $urandom_range(0, 1);
            if (c >= waits + 2) dri_rdata = {1'b1, rd_i};
            else                dri_rdata = {1'b0, $urandom};
        end
        if (done != 2'b11) chk("ack_timeout", done, 2'b11);
        req = 2'b00;
        dri_rdata = {1'b0, $urandom};
        @(negedge clk);
    endtask

    initial begin
        int t1, t2, nack;
        logic [31:0] d;
        rst = 1'b1; req = 2'b00; we = 1'b0; addr = 8'h0; wdata = 32'h0;
        dri_rdata = '0; intr = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", ack_w[k], 1'b0);
            chk("rst_err", err_w[k], 1'b0);
            chk("rst_irq", irq_w[k], 1'b0);
            chk("rst_ctrl", ctrl_w[k], 11'h0);
            chk("rst_dwd", dwd_w[k], 33'h0);
            chk("rst_rdata", rdata_w[k], 32'h0);
            chk("rst_arstn", arstn_w[k], 1'b0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arstn_up", arstn_w[0], 1'b1);

        // Directed: write with immediate PREADY
        do_txn(1'b1, 8'h08, 32'hDEADBEEF, 0, 32'h0);
        // Directed: read with 5 wait states (times out on the TIMEOUT=4 instance)
        do_txn(1'b0, 8'h10, 32'h0, 5, 32'h12345678);
        // Directed: PREADY rises in the 4th ACCESS cycle -> no error on either
        do_txn(1'b0, 8'h22, 32'h0, 3, 32'hA5A5_0F0F);
        // Directed: PREADY stuck low -> both instances time out
        do_txn(1'b0, 8'h33, 32'h0, 1000, 32'hFFFF_FFFF);
        // Randomized accesses
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                   int'($urandom_range(0, 7)), $urandom);
        end

        // Back-to-back reads with REQ held high
        d = $urandom;
        we = 1'b0; addr = 8'h44; req = 2'b01; dri_rdata = {1'b1, d};
        t1 = -1; t2 = -1; nack = 0;
        for (int c = 1; c <= 20 && nack < 2; c++) begin
            @(negedge clk);
            if (ack_w[0]) begin
                nack++;
                if (nack == 1) t1 = c;
                else begin t2 = c; req = 2'b00; end
            end
        end
        exp_rd[0] = d;
        chk("b2b_first", t1, 3);
        chk("b2b_gap", t2 - t1, 4);
        chk("b2b_rdata", rdata_w[0], exp_rd[0]);
        dri_rdata = '0;
        @(negedge clk);

        // Reset in the middle of ACCESS
        we = 1'b1; addr = 8'h55; wdata = $urandom; req = 2'b11; dri_rdata = '0;
        repeat (3) @(negedge clk);
        chk("pre_rst_ctrl", ctrl_w[0], {3'b111, 8'h55});
        #1 rst = 1'b1;
        #1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        chk("mid_rst_ctrl", ctrl_w[0], 11'h0);
        chk("mid_rst_ack", ack_w[0], 1'b0);
        chk("mid_rst_arstn", arstn_w[0], 1'b0);
        chk("mid_rst_dwd", dwd_w[1], 33'h0);
        chk("mid_rst_rdata", rdata_w[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_edge1_arstn", arstn_w[0], 1'b0);
        chk("rel_edge1_ctrl", ctrl_w[0], 11'h0);
        @(posedge clk); #1;
        chk("rel_edge2_arstn", arstn_w[0], 1'b1);
        chk("rel_edge2_ctrl", ctrl_w[0], 11'h0);
        @(posedge clk); #1;
        chk("rel_setup_ctrl", ctrl_w[1], {3'b101, 8'h55});
        dri_rdata = {1'b1, 32'h0};
        nack = 0;
        for (int c = 0; c < 10 && ack_w != 2'b11; c++) @(negedge clk);
        chk("rel_ack", ack_w, 2'b11);
        chk("rel_rdata", rdata_w[0], exp_rd[0]);
        req = 2'b00;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pll_dri_master
`default_nettype wire
